// File: rtl/aes_pkg.sv
// Shared AES types and constants used by the round datapath and its I/O stages.
package aes_pkg;

   typedef logic [7:0] byte_t;
   typedef byte_t [15:0] state_t;

   localparam int AES_NBYTES          = 16;
   localparam int AES_WORDS_PER_BLOCK = 4;

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } rd_state_e;

endpackage

// File: rtl/aes_out_slot.sv
// One buffered AES state for the output serializer: data register, FULL flag
// and a 32-bit word-select mux (byte 4k+j lands on bits 8j+:8 of word k).
module aes_out_slot
   import aes_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        load,
   input  logic        clear,
   input  state_t      d,
   input  logic [1:0]  sel,
   output logic        full,
   output logic [31:0] word
);

   state_t data_q, data_d;
   logic   full_q, full_d;

   always_comb begin
      data_d = data_q;
      full_d = full_q;
      if (load) begin
         data_d = d;
         full_d = 1'b1;
      end else if (clear) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         data_q <= '0;
         full_q <= 1'b0;
      end else begin
         data_q <= data_d;
         full_q <= full_d;
      end
   end

   assign full = full_q;
   assign word = data_q[{sel, 2'b00} +: 4];

endmodule

// File: rtl/aes_out_serializer.sv
// Serializes a 16-byte AES state into four 32-bit words over valid/ready.
// Define AES_OUT_PINGPONG_EN for two alternating buffer slots (default: one).
//
//   state | meaning
//   IDLE  | oldest slot empty, o_valid low
//   SEND  | oldest slot full, word n_rd on o
module aes_out_serializer
   import aes_pkg::*;
#(
   parameter int NBYTES = AES_NBYTES,
   parameter int WORD_W = 32
)
(
   input  logic                   clk,
   input  logic                   reset,
   input  logic [NBYTES-1:0][7:0] i,
   input  logic                   i_valid,
   output logic                   i_ready,
   output logic [WORD_W-1:0]      o,
   output logic                   o_valid,
   input  logic                   o_ready,
   output logic                   o_last,
   output logic                   busy
);

`ifdef AES_OUT_PINGPONG_EN
   localparam int NSLOT = 2;
`else
   localparam int NSLOT = 1;
`endif

   rd_state_e         state_q, state_d;
   logic [1:0]        n_rd_q, n_rd_d;
   logic [NSLOT-1:0]  slot_load, slot_clear, slot_full, full_next;
   logic [WORD_W-1:0] slot_word [NSLOT];
   logic [WORD_W-1:0] rd_word;
   logic              load, hs, drain, wr_full, rd_full_next;

   for (genvar s = 0; s < NSLOT; s++) begin : g_slot
      aes_out_slot u_slot (
         .clk   (clk),
         .reset (reset),
         .load  (slot_load[s]),
         .clear (slot_clear[s]),
         .d     (i),
         .sel   (n_rd_q),
         .full  (slot_full[s]),
         .word  (slot_word[s])
      );
   end

   assign hs        = o_valid && o_ready;
   assign drain     = hs && (n_rd_q == 2'd3);
   assign i_ready   = !wr_full;
   assign load      = i_valid && !wr_full;
   assign full_next = (slot_full | slot_load) & ~slot_clear;

`ifdef AES_OUT_PINGPONG_EN
   logic wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;

   // Slots fill and drain in the same order, so the write slot is empty whenever any slot is.
   assign wr_ptr_d     = wr_ptr_q ^ load;
   assign rd_ptr_d     = rd_ptr_q ^ drain;
   assign wr_full      = slot_full[wr_ptr_q];
   assign rd_word      = slot_word[rd_ptr_q];
   assign slot_load    = {load & wr_ptr_q, load & ~wr_ptr_q};
   assign slot_clear   = {drain & rd_ptr_q, drain & ~rd_ptr_q};
   assign rd_full_next = full_next[rd_ptr_d];

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end
`else
   assign wr_full      = slot_full[0];
   assign rd_word      = slot_word[0];
   assign slot_load    = load;
   assign slot_clear   = drain;
   assign rd_full_next = full_next[0];
`endif

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         n_rd_q  <= 2'd0;
      end else begin
         state_q <= state_d;
         n_rd_q  <= n_rd_d;
      end
   end

   // Next state looks at the slot that will be oldest after this edge, so word 0 shows one edge after load.
   always_comb begin
      state_d = state_q;
      n_rd_d  = n_rd_q;
      case (state_q)
         IDLE: begin
            if (rd_full_next) state_d = SEND;
         end
         SEND: begin
            if (hs) n_rd_d = n_rd_q + 2'd1;
            if (drain) state_d = rd_full_next ? SEND : IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      o_valid = (state_q == SEND);
      o_last  = o_valid && (n_rd_q == 2'd3);
      o       = o_valid ? rd_word : '0;
      busy    = |slot_full;
   end

endmodule

// File: tb/tb_aes_out_serializer.sv
// Directed bench for aes_out_serializer; builds with or without AES_OUT_PINGPONG_EN.
module tb_aes_out_serializer;
   import aes_pkg::*;

`ifdef AES_OUT_PINGPONG_EN
   localparam longint BB_LOAD_GAP = 10;
   localparam longint BB_SPAN     = 70;
   localparam logic   RDY_2ND     = 1'b1;
`else
   localparam longint BB_LOAD_GAP = 50;
   localparam longint BB_SPAN     = 80;
   localparam logic   RDY_2ND     = 1'b0;
`endif

   logic              clk = 1'b0;
   logic              reset = 1'b1;
   logic [15:0][7:0]  i = '0;
   logic              i_valid = 1'b0;
   logic              i_ready;
   logic [31:0]       o;
   logic              o_valid;
   logic              o_ready = 1'b0;
   logic              o_last;
   logic              busy;

   int          checks = 0;
   int          errors = 0;
   logic [32:0] exp_q[$];
   longint      hs_t[$];
   longint      load_edge;
   longint      load_a, load_b;
   logic        stalled = 1'b0;
   logic [31:0] prev_o = '0;

   aes_out_serializer dut (
      .clk     (clk),
      .reset   (reset),
      .i       (i),
      .i_valid (i_valid),
      .i_ready (i_ready),
      .o       (o),
      .o_valid (o_valid),
      .o_ready (o_ready),
      .o_last  (o_last),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s obs=%h exp=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   function automatic state_t seq_state(input logic [7:0] b);
      state_t s;
      for (int j = 0; j < 16; j++) s[j] = b + 8'(j);
      return s;
   endfunction

   function automatic logic [127:0] seq_words(input logic [7:0] b);
      logic [127:0] w;
      for (int j = 0; j < 16; j++) w[8*j +: 8] = b + 8'(j);
      return w;
   endfunction

   // Input-collector model: byte j of word k goes to state byte 4k+j.
   function automatic state_t collect(input logic [31:0] w0, w1, w2, w3);
      state_t s;
      logic [127:0] cat;
      cat = {w3, w2, w1, w0};
      for (int j = 0; j < 16; j++) s[j] = cat[8*j +: 8];
      return s;
   endfunction

   task automatic send_state(input state_t s, input logic [127:0] w);
      int t;
      t = 0;
      i = s;
      i_valid = 1'b1;
      while (!i_ready && t < 50) begin
         cyc(1);
         t++;
      end
      check_eq("load_ready", 32'(i_ready), 32'd1);
      @(posedge clk);
      load_edge = $time;
      #1;
      i_valid = 1'b0;
      for (int k = 0; k < 4; k++) exp_q.push_back({(k == 3), w[32*k +: 32]});
   endtask

   task automatic wait_empty();
      int t;
      t = 0;
      while ((exp_q.size() != 0 || busy) && t < 100) begin
         cyc(1);
         t++;
      end
      check_eq("drain_done", 32'(exp_q.size()), 32'd0);
      check_eq("busy_idle", 32'(busy), 32'd0);
      check_eq("valid_idle", 32'(o_valid), 32'd0);
   endtask

   // Output monitor: ordered word/last scoreboard plus hold-while-stalled checks.
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (reset) begin
            stalled = 1'b0;
         end else begin
            if (stalled) begin
               check_eq("hold_valid", 32'(o_valid), 32'd1);
               check_eq("hold_o", o, prev_o);
            end
            if (o_valid && o_ready) begin
               hs_t.push_back($time + 5);
               if (exp_q.size() == 0) begin
                  check_eq("extra_word", o, 32'hxxxxxxxx);
               end else begin
                  e = exp_q.pop_front();
                  check_eq("word", o, e[31:0]);
                  check_eq("last", 32'(o_last), 32'(e[32]));
               end
            end else begin
               check_eq("last_idle", 32'(o_last), 32'(o_valid && o_last));
            end
            stalled = o_valid && !o_ready;
            prev_o  = o;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout obs=running exp=finished");
      $fatal(1, "bench timeout");
   end

   initial begin
      cyc(3);
      reset = 1'b0;
      check_eq("rst_o", o, 32'h0);
      check_eq("rst_valid", 32'(o_valid), 32'd0);
      check_eq("rst_last", 32'(o_last), 32'd0);
      check_eq("rst_iready", 32'(i_ready), 32'd1);
      check_eq("rst_busy", 32'(busy), 32'd0);

      // single block, free-running output
      o_ready = 1'b1;
      hs_t.delete();
      send_state(seq_state(8'h00), {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100});
      check_eq("lat_valid", 32'(o_valid), 32'd1);
      check_eq("lat_o", o, 32'h03020100);
      check_eq("lat_busy", 32'(busy), 32'd1);
      wait_empty();
      check_eq("single_span", 32'(hs_t[3] - hs_t[0]), 32'd30);

      // stall three cycles on word 1
      o_ready = 1'b0;
      send_state(seq_state(8'h00), {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100});
      o_ready = 1'b1;
      cyc(1);
      o_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc(1);
         check_eq("stall_o", o, 32'h07060504);
         check_eq("stall_valid", 32'(o_valid), 32'd1);
      end
      o_ready = 1'b1;
      wait_empty();

      // two blocks back to back
      hs_t.delete();
      send_state(seq_state(8'h00), {32'h0F0E0D0C, 32'h0B0A0908, 32'h07060504, 32'h03020100});
      load_a = load_edge;
      check_eq("bb_iready", 32'(i_ready), 32'(RDY_2ND));
      send_state(seq_state(8'h10), {32'h1F1E1D1C, 32'h1B1A1918, 32'h17161514, 32'h13121110});
      load_b = load_edge;
      check_eq("bb_load_gap", 32'(load_b - load_a), 32'(BB_LOAD_GAP));
      wait_empty();
      check_eq("bb_words", 32'(hs_t.size()), 32'd8);
      check_eq("bb_span", 32'(hs_t[7] - hs_t[0]), 32'(BB_SPAN));

`ifdef AES_OUT_PINGPONG_EN
      // both slots full: third block waits for first slot's word 3
      o_ready = 1'b0;
      hs_t.delete();
      send_state(seq_state(8'h40), seq_words(8'h40));
      send_state(seq_state(8'h50), seq_words(8'h50));
      i = seq_state(8'h60);
      i_valid = 1'b1;
      cyc(2);
      check_eq("full_iready", 32'(i_ready), 32'd0);
      check_eq("full_busy", 32'(busy), 32'd1);
      o_ready = 1'b1;
      send_state(seq_state(8'h60), seq_words(8'h60));
      check_eq("third_load", 32'(load_edge - hs_t[3]), 32'd10);
      wait_empty();
`endif

      // reset after word 1 handshake
      o_ready = 1'b1;
      send_state(seq_state(8'h20), seq_words(8'h20));
      cyc(2);
      o_ready = 1'b0;
      reset = 1'b1;
      cyc(1);
      check_eq("mrst_valid", 32'(o_valid), 32'd0);
      check_eq("mrst_busy", 32'(busy), 32'd0);
      check_eq("mrst_iready", 32'(i_ready), 32'd1);
      check_eq("mrst_o", o, 32'h0);
      reset = 1'b0;
      exp_q.delete();
      o_ready = 1'b1;
      send_state(seq_state(8'h30), {32'h3F3E3D3C, 32'h3B3A3938, 32'h37363534, 32'h33323130});
      wait_empty();

      // round trip through the collector model
      send_state(collect(32'hDEADBEEF, 32'h01234567, 32'h89ABCDEF, 32'hCAFEF00D),
                 {32'hCAFEF00D, 32'h89ABCDEF, 32'h01234567, 32'hDEADBEEF});
      wait_empty();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
